// File: rtl/jk_pkg.sv
// jk_pkg: types and constants shared by the JK drive sequencer.
//   jk_state_t : sequencer FSM states
//   jk_code_t  : excitation code, packed as {j, k}
//   JK_*       : excitation codes for hold / reset / set / toggle
//   ERR_MAX    : saturation value of the mismatch counter
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } jk_state_t;

  typedef logic [1:0] jk_code_t;

  localparam jk_code_t JK_HOLD   = 2'b00;
  localparam jk_code_t JK_RESET  = 2'b01;
  localparam jk_code_t JK_SET    = 2'b10;
  localparam jk_code_t JK_TOGGLE = 2'b11;

  localparam logic [7:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/jk_excite.sv
// jk_excite: JK excitation table. Given the present flop output and the
// wanted next value, produce the J/K command that gets there.
//   q          : present q of the driven flop
//   t          : target value for the next edge
//   use_toggle : 1 = use J=K=1 for any change, 0 = set/reset commands
//   j, k       : excitation outputs (combinational)
module jk_excite
  import jk_pkg::*;
(
  input  logic q,
  input  logic t,
  input  logic use_toggle,
  output logic j,
  output logic k
);

  jk_code_t code;

  always_comb begin
    code = JK_HOLD;
    if (q != t) begin
      if (use_toggle)
        code = JK_TOGGLE;
      else if (t)
        code = JK_SET;
      else
        code = JK_RESET;
    end
  end

  assign j = code[1];
  assign k = code[0];

endmodule

// File: rtl/jk_drive_seq.sv
// jk_drive_seq: drives an external JK flip-flop through a target bit pattern,
// MSB first, one DRIVE/CHECK cycle pair per bit, and records what the flop
// actually produced.
//   clk, rst          : clock, synchronous active-high reset
//   in_data, in_valid : target word and its qualifier
//   in_ready          : word accepted at this edge when in_valid is also 1
//   q_fb              : q of the driven flop
//   j, k              : commands to the driven flop (only nonzero in DRIVE)
//   clr_err           : synchronous clear of err_cnt, wins over a mismatch
//   busy, done        : word in progress / one-cycle completion pulse
//   obs_data          : q values sampled in each CHECK, MSB first
//   err_cnt           : saturating count of target/q mismatches
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for a word, in_ready=1
// ST_DRIVE | j/k applied for the current bit; flop updates at the edge
// ST_CHECK | sample q_fb into obs_data, count mismatch, step bit index
// ST_DONE  | one-cycle done pulse, then back to IDLE
module jk_drive_seq
  import jk_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int USE_TOGGLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  input  logic             clr_err,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] obs_data,
  output logic [7:0]       err_cnt
);

  localparam int IW = $clog2(WIDTH);

  jk_state_t        state;
  logic [WIDTH-1:0] tgt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] obs;
  logic [7:0]       err;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;

  logic t_bit;
  logic j_x;
  logic k_x;
  logic drive_en;
  logic accept;
  logic mismatch;

  // idx is held between DRIVE and CHECK, so both see the same target bit.
  assign t_bit    = tgt[idx];
  assign accept   = ready_r && in_valid;
  assign mismatch = (state == ST_CHECK) && (q_fb != t_bit);

  // Gating with rst keeps j/k and in_ready quiet throughout a reset cycle,
  // even before the reset edge has moved the FSM to IDLE.
  assign drive_en = (state == ST_DRIVE) && !rst;

  jk_excite u_excite (
    .q          (q_fb),
    .t          (t_bit),
    .use_toggle (USE_TOGGLE != 0),
    .j          (j_x),
    .k          (k_x)
  );

  assign j        = j_x & drive_en;
  assign k        = k_x & drive_en;
  assign in_ready = ready_r & ~rst;
  assign busy     = busy_r;
  assign done     = done_r;
  assign obs_data = obs;
  assign err_cnt  = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tgt     <= '0;
      idx     <= '0;
      obs     <= '0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            tgt     <= in_data;
            idx     <= IW'(WIDTH - 1);
            obs     <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state   <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          obs <= {obs[WIDTH-2:0], q_fb};
          if (idx == '0) begin
            done_r <= 1'b1;
            state  <= ST_DONE;
          end else begin
            idx   <= idx - 1'b1;
            state <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_err)
      err <= '0;
    else if (mismatch && (err != ERR_MAX))
      err <= err + 8'd1;
  end

endmodule

// File: tb/tb_jk_drive_seq.sv
// Directed bench: two sequencers (set/reset and toggle excitation), each
// driving its own behavioural JK flop that starts at q=0.
module tb_jk_drive_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst;
  logic [1:0] in_valid;
  logic [1:0] in_ready;
  logic [1:0] q_fb;
  logic [1:0] j;
  logic [1:0] k;
  logic [1:0] clr_err;
  logic [1:0] busy;
  logic [1:0] done;
  logic [1:0] stuck;
  logic [1:0] fq = 2'b00;
  logic [7:0] in_data0, in_data1;
  logic [7:0] obs0, obs1, err0, err1;

  int n_chk  = 0;
  int n_fail = 0;

  jk_drive_seq #(.WIDTH(8), .USE_TOGGLE(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .in_data(in_data0), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .q_fb(q_fb[0]), .j(j[0]), .k(k[0]),
    .clr_err(clr_err[0]), .busy(busy[0]), .done(done[0]),
    .obs_data(obs0), .err_cnt(err0)
  );

  jk_drive_seq #(.WIDTH(8), .USE_TOGGLE(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .in_data(in_data1), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .q_fb(q_fb[1]), .j(j[1]), .k(k[1]),
    .clr_err(clr_err[1]), .busy(busy[1]), .done(done[1]),
    .obs_data(obs1), .err_cnt(err1)
  );

  // Behavioural JK flops
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      case ({j[i], k[i]})
        2'b10:   fq[i] <= 1'b1;
        2'b01:   fq[i] <= 1'b0;
        2'b11:   fq[i] <= ~fq[i];
        default: fq[i] <= fq[i];
      endcase
    end
  end

  assign q_fb = fq & ~stuck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_data(input int u, input logic [7:0] d);
    if (u == 0) in_data0 = d;
    else        in_data1 = d;
  endtask

  function automatic logic [7:0] obs_of(input int u);
    return (u == 0) ? obs0 : obs1;
  endfunction

  function automatic logic [7:0] err_of(input int u);
    return (u == 0) ? err0 : err1;
  endfunction

  // Full per-bit word check. Called at a negedge in IDLE. The accept cycle is
  // cycle 1; DRIVE/CHECK pairs fill cycles 2..17 and done must first appear
  // in cycle 18. exp_jk holds {j,k} per bit, bit 7 in the top pair.
  task automatic run_word(input int u, input logic [7:0] data,
                          input logic [15:0] exp_jk, input logic [7:0] exp_q,
                          input bit hold, input string tag);
    set_data(u, data);
    in_valid[u] = 1'b1;
    #1 chk({tag, " ready"}, in_ready[u], 1);
    @(negedge clk);
    if (!hold) in_valid[u] = 1'b0;
    for (int b = 7; b >= 0; b--) begin
      if (hold) set_data(u, data ^ 8'(8'h11 * (b + 1)));
      #1;
      chk({tag, " j"}, j[u], exp_jk[2*b+1]);
      chk({tag, " k"}, k[u], exp_jk[2*b]);
      chk({tag, " busy"}, busy[u], 1);
      chk({tag, " done early"}, done[u], 0);
      chk({tag, " ready busy"}, in_ready[u], 0);
      @(negedge clk);
      #1;
      chk({tag, " jk in check"}, {j[u], k[u]}, 0);
      chk({tag, " q"}, q_fb[u], exp_q[b]);
      @(negedge clk);
    end
    #1;
    chk({tag, " done"}, done[u], 1);
    chk({tag, " busy in done"}, busy[u], 1);
    chk({tag, " jk in done"}, {j[u], k[u]}, 0);
    in_valid[u] = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, " done pulse"}, done[u], 0);
    chk({tag, " idle busy"}, busy[u], 0);
    chk({tag, " idle ready"}, in_ready[u], 1);
    chk({tag, " obs"}, obs_of(u), exp_q);
  endtask

  // Send a word and wait (bounded) for done; checks the done cycle is 18.
  task automatic fast_word(input int u, input logic [7:0] data, input string tag);
    int cyc;
    set_data(u, data);
    in_valid[u] = 1'b1;
    @(negedge clk);
    in_valid[u] = 1'b0;
    cyc = 2;
    while (cyc < 40) begin
      #1;
      if (done[u]) break;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done cycle"}, cyc, 18);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    rst      = 2'b11;
    in_valid = 2'b00;
    clr_err  = 2'b00;
    stuck    = 2'b00;
    in_data0 = 8'h00;
    in_data1 = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst ready", in_ready[0], 0);
    chk("rst busy", busy[0], 0);
    chk("rst done", done[0], 0);
    chk("rst jk", {j[0], k[0]}, 0);
    chk("rst obs", obs0, 8'h00);
    chk("rst err", err0, 8'h00);
    rst = 2'b00;
    #1 chk("ready after rst", in_ready[0], 1);
    @(negedge clk);

    // Set/reset excitation from q=0: 10,01,10,01,00,10,01,10
    run_word(0, 8'hA5, 16'h9926, 8'hA5, 1'b0, "a5");
    chk("a5 err", err0, 8'h00);

    // Toggle excitation: only the first bit changes q in each word
    run_word(1, 8'hFF, 16'hC000, 8'hFF, 1'b0, "ff");
    run_word(1, 8'h00, 16'hC000, 8'h00, 1'b0, "00");
    chk("tog err", err1, 8'h00);

    // in_valid held with changing data while busy; from q=0:
    // 00,11,11,11,00,11,11,11
    run_word(1, 8'h5A, 16'h3F3F, 8'h5A, 1'b1, "hold");
    chk("hold err", err1, 8'h00);

    // q stuck at 0: upper nibble mismatches, drive always asks for set
    stuck[0] = 1'b1;
    run_word(0, 8'hF0, 16'hAA00, 8'h00, 1'b0, "stuck");
    chk("stuck err", err0, 8'd4);
    for (int w = 0; w < 62; w++) fast_word(0, 8'hF0, "sat");
    chk("err 252", err0, 8'd252);
    fast_word(0, 8'hF0, "sat");
    fast_word(0, 8'hF0, "sat");
    chk("err saturated", err0, 8'd255);

    // clr_err in a mismatching CHECK wins; three more mismatches follow
    in_data0 = 8'hF0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    clr_err[0] = 1'b1;
    @(negedge clk);
    clr_err[0] = 1'b0;
    #1 chk("clr wins", err0, 8'd0);
    done_seen = 0;
    for (int c = 0; c < 30 && done_seen == 0; c++) begin
      @(negedge clk);
      #1 if (done[0]) done_seen = 1;
    end
    chk("clr word done", done_seen, 1);
    @(negedge clk);
    chk("err after clr", err0, 8'd3);
    clr_err[0] = 1'b1;
    @(negedge clk);
    clr_err[0] = 1'b0;
    #1 chk("clr in idle", err0, 8'd0);

    // Reset during bit 3 (DRIVE of bit 3 is cycle 10)
    stuck[0] = 1'b0;
    in_data0 = 8'h3C;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (8) @(negedge clk);
    #1 chk("bit3 busy", busy[0], 1);
    rst[0] = 1'b1;
    #1 chk("rst jk gated", {j[0], k[0]}, 0);
    @(negedge clk);
    #1;
    chk("abort busy", busy[0], 0);
    chk("abort done", done[0], 0);
    chk("abort jk", {j[0], k[0]}, 0);
    chk("abort ready", in_ready[0], 0);
    chk("abort obs", obs0, 8'h00);
    rst[0] = 1'b0;
    #1 chk("abort ready after", in_ready[0], 1);
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1 if (done[0]) done_seen++;
    end
    chk("abort no done", done_seen, 0);
    fast_word(0, 8'h96, "recover");
    chk("recover obs", obs0, 8'h96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_drive_seq.md
JK_DRIVE_SEQ -- requirements
Module: jk_drive_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the target word width in bits (2..32).
REQ-002 The block SHALL have parameter USE_TOGGLE, default 0; 1 selects J=K=1 for every state change, 0 selects set/reset excitation.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port in_data  input  WIDTH  target bit pattern, shifted MSB first.
REQ-006 Port in_valid  input  1  in_data valid.
REQ-007 Port in_ready  output  1  block accepts a word this cycle.
REQ-008 Port q_fb  input  1  q output of the driven JK flip-flop.
REQ-009 Port j  output  1  J command to the driven flip-flop.
REQ-010 Port k  output  1  K command to the driven flip-flop.
REQ-011 Port clr_err  input  1  synchronous clear of err_cnt.
REQ-012 Port busy  output  1  word in progress.
REQ-013 Port done  output  1  one-cycle pulse at word completion.
REQ-014 Port obs_data  output  WIDTH  q values sampled during the word, MSB first.
REQ-015 Port err_cnt  output  8  saturating count of bit mismatches.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, CHECK and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a word is accepted at an edge where in_ready and in_valid are both 1, loading the shift register, setting bit index WIDTH-1 and moving to DRIVE.
REQ-018 In DRIVE, j/k SHALL be combinational from q_fb and target bit t: q=t gives j=0,k=0; q=0,t=1 gives j=1,k=0 (or j=1,k=1 if USE_TOGGLE); q=1,t=0 gives j=0,k=1 (or j=1,k=1 if USE_TOGGLE).
REQ-019 Outside DRIVE, j and k SHALL both be 0.
REQ-020 DRIVE SHALL last exactly one cycle and always transition to CHECK.
REQ-021 In CHECK, q_fb SHALL be shifted into obs_data LSB; if q_fb differs from t, err_cnt increments, saturating at 255.
REQ-022 From CHECK, the FSM SHALL go to DONE after bit index 0, otherwise decrement the index and return to DRIVE.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE; obs_data holds until the next accept.
REQ-024 A word SHALL take 1 + 2*WIDTH + 1 cycles from the accept edge to return to IDLE.
REQ-025 busy SHALL be 1 in DRIVE, CHECK and DONE.
REQ-026 clr_err SHALL zero err_cnt in any state; when coincident with a mismatch, the clear wins and the mismatch is not counted.
REQ-027 in_valid and in_data SHALL be ignored outside IDLE.

Reset
REQ-028 While rst=1 at an edge, the FSM SHALL go to IDLE, clearing obs_data, err_cnt, the shift register and the bit index; done=0, busy=0, j=k=0, in_ready=0 during the reset cycle.
REQ-029 A reset mid-word SHALL abort the word without a done pulse; in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-030 The shared package jk_pkg SHALL hold the state enumeration and the excitation-code constants.
REQ-031 The excitation table SHALL be a sub-module jk_excite (inputs q, t, use_toggle; outputs j, k), instantiated once.

Verification (bench drives jk_drive_seq plus a behavioural JK flip-flop initialised to q=0, 10 ns clock)
REQ-032 Accept 8'hA5 with USE_TOGGLE=0 -> flop q sequence 1,0,1,0,0,1,0,1, obs_data=8'hA5, err_cnt=0, done at cycle 18 after the accept.
REQ-033 Accept 8'hFF then 8'h00 with USE_TOGGLE=1 -> first bit j=k=1, later bits j=k=0, obs_data=8'hFF then 8'h00, err_cnt=0.
REQ-034 Force q_fb stuck-at-0 and send 8'hF0 -> err_cnt=4, obs_data=8'h00; after 64 further words err_cnt=255, no wrap.
REQ-035 Assert clr_err in a CHECK cycle that has a mismatch -> err_cnt=0 next cycle.
REQ-036 Assert rst during bit 3 of a word -> next cycle IDLE, j=k=0, no done pulse, in_ready=1 after rst falls.
REQ-037 Hold in_valid=1 with a changing in_data while busy -> only the word present at the accept edge is driven.
